// File: rtl/hist_pingpong_builder.sv
// dToF histogram builder: two ping-pong banks of saturating bin counters.
// One bank accumulates hits via a forwarded read-modify-write pipeline while the other streams out and self-clears.
module hist_pingpong_builder #(
  parameter int NB      = 8,
  parameter int CW      = 12,
  parameter int NPIX    = 4,
  parameter int ACQ_NUM = 1024,
  localparam int PW     = $clog2(NPIX)
) (
  input  logic          clk,
  input  logic          res,
  input  logic          laser_sync,
  input  logic          ts_valid,
  input  logic [PW-1:0] ts_pix,
  input  logic [NB-1:0] ts_bin,
  input  logic          rd_ready,
  output logic          rd_valid,
  output logic [CW-1:0] rd_data,
  output logic [PW-1:0] rd_pix,
  output logic [NB-1:0] rd_bin,
  output logic          rd_last,
  output logic          ready,
  output logic          frame_done,
  output logic          next_flag,
  output logic [15:0]   drop_cnt
);

  localparam int AW    = PW + NB;
  localparam int DEPTH = 1 << AW;
  localparam int AQW   = $clog2(ACQ_NUM + 1);
  localparam logic [AW-1:0]  LAST_A  = '1;
  localparam logic [CW-1:0]  CMAX    = '1;
  localparam logic [AQW-1:0] ACQ_END = AQW'(ACQ_NUM);

  typedef enum logic [1:0] {S_INIT, S_ACQ, S_FLUSH, S_WAIT} state_t;

  function automatic logic [CW-1:0] sat_inc_cnt(input logic [CW-1:0] x);
    return (x == CMAX) ? x : x + 1'b1;
  endfunction

  function automatic logic [15:0] sat_inc_drop(input logic [15:0] x);
    return (x == 16'hFFFF) ? x : x + 16'd1;
  endfunction

  state_t         state_q, state_d;
  logic [AQW-1:0] acq_cnt_q, acq_cnt_d;
  logic           flush_q, flush_d;
  logic [AW-1:0]  init_cnt_q, init_cnt_d;
  logic           wb_q, wb_d;
  logic           frame_done_q, frame_done_d;
  logic           next_flag_q, next_flag_d;
  logic [15:0]    drop_q, drop_d;
  logic           swap;
  logic           hit_acc;

  // Bank ports and memories
  logic [CW-1:0] mem [2][DEPTH];
  logic [CW-1:0] brd_q [2];
  logic          bwe [2];
  logic [AW-1:0] bwa [2];
  logic [CW-1:0] bwd [2];
  logic [AW-1:0] bra [2];

  // Build pipeline
  logic [AW-1:0] addr_p0;
  logic          vld_p1_q, vld_p2_q;
  logic [AW-1:0] addr_p1_q, addr_p2_q;
  logic [CW-1:0] data_p2_q;
  logic [CW-1:0] cnt_old_p1, cnt_new_p1;

  // Reader
  logic          rd_busy_q, rd_iss_q;
  logic [AW-1:0] ra_q;
  logic          iss_vld_q;
  logic [AW-1:0] iss_addr_q;
  logic          out_vld_q;
  logic [CW-1:0] out_data_q;
  logic [AW-1:0] out_addr_q;
  logic          sk_vld_q;
  logic [CW-1:0] sk_data_q;
  logic [AW-1:0] sk_addr_q;
  logic [CW-1:0] rd_in_data;
  logic [1:0]    occ;
  logic          pop, rd_last_w, rd_idle, rd_issue, out_load, to_skid;

  assign pop        = out_vld_q & rd_ready;
  assign rd_last_w  = out_vld_q && (out_addr_q == LAST_A);
  assign rd_idle    = !rd_busy_q || (pop && rd_last_w);
  assign occ        = 2'(out_vld_q) + 2'(sk_vld_q) + 2'(iss_vld_q);
  assign rd_issue   = rd_iss_q && ((occ < 2'd2) || ((occ == 2'd2) && pop));
  assign out_load   = pop || !out_vld_q;
  assign to_skid    = iss_vld_q && (out_load ? sk_vld_q : 1'b1);
  assign rd_in_data = brd_q[!wb_q];

  always_comb begin
    state_d      = state_q;
    acq_cnt_d    = acq_cnt_q;
    flush_d      = flush_q;
    init_cnt_d   = init_cnt_q;
    wb_d         = wb_q;
    frame_done_d = 1'b0;
    next_flag_d  = next_flag_q;
    drop_d       = drop_q;
    swap         = 1'b0;
    hit_acc      = 1'b0;
    case (state_q)
      S_INIT: begin
        init_cnt_d = init_cnt_q + 1'b1;
        if (init_cnt_q == LAST_A) state_d = S_ACQ;
      end
      S_ACQ: begin
        hit_acc = ts_valid;
        if (laser_sync) begin
          acq_cnt_d = acq_cnt_q + 1'b1;
          if (acq_cnt_d == ACQ_END) begin
            state_d = S_FLUSH;
            flush_d = 1'b0;
          end
        end
      end
      S_FLUSH: begin
        flush_d = 1'b1;
        if (flush_q) begin
          if (rd_idle) swap = 1'b1;
          else         state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (rd_idle) swap = 1'b1;
      end
      default: state_d = S_INIT;
    endcase
    if (swap) begin
      state_d      = S_ACQ;
      wb_d         = !wb_q;
      frame_done_d = 1'b1;
      next_flag_d  = !next_flag_q;
      acq_cnt_d    = '0;
    end
    if (ts_valid && (state_q != S_ACQ)) drop_d = sat_inc_drop(drop_q);
  end

  always_ff @(posedge clk) begin
    if (res) begin
      state_q      <= S_INIT;
      acq_cnt_q    <= '0;
      flush_q      <= 1'b0;
      init_cnt_q   <= '0;
      wb_q         <= 1'b0;
      frame_done_q <= 1'b0;
      next_flag_q  <= 1'b0;
      drop_q       <= '0;
    end else begin
      state_q      <= state_d;
      acq_cnt_q    <= acq_cnt_d;
      flush_q      <= flush_d;
      init_cnt_q   <= init_cnt_d;
      wb_q         <= wb_d;
      frame_done_q <= frame_done_d;
      next_flag_q  <= next_flag_d;
      drop_q       <= drop_d;
    end
  end

  // p0: hit address issues the bank read
  assign addr_p0 = {ts_pix, ts_bin};

  // p1: the previous write is not yet visible in the read data, so forward it
  assign cnt_old_p1 = (vld_p2_q && (addr_p2_q == addr_p1_q)) ? data_p2_q : brd_q[wb_q];
  assign cnt_new_p1 = sat_inc_cnt(cnt_old_p1);

  always_ff @(posedge clk) begin
    if (res) begin
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
    end else begin
      vld_p1_q <= hit_acc;
      vld_p2_q <= vld_p1_q;
    end
  end

  // p2: last written entry held for forwarding
  always_ff @(posedge clk) begin
    addr_p1_q <= addr_p0;
    addr_p2_q <= addr_p1_q;
    data_p2_q <= cnt_new_p1;
  end

  always_comb begin
    for (int b = 0; b < 2; b++) begin
      bwe[b] = 1'b0;
      bwa[b] = '0;
      bwd[b] = '0;
      bra[b] = ra_q;
      if (state_q == S_INIT) begin
        bwe[b] = 1'b1;
        bwa[b] = init_cnt_q;
      end else if (b[0] == wb_q) begin
        bwe[b] = vld_p1_q;
        bwa[b] = addr_p1_q;
        bwd[b] = cnt_new_p1;
      end else begin
        bwe[b] = pop;
        bwa[b] = out_addr_q;
      end
      if (b[0] == wb_q) bra[b] = addr_p0;
    end
  end

  always_ff @(posedge clk) begin
    for (int b = 0; b < 2; b++) begin
      if (bwe[b]) mem[b][bwa[b]] <= bwd[b];
      brd_q[b] <= mem[b][bra[b]];
    end
  end

  // Reader: issue -> read data -> output/skid; at most two beats in flight or held
  always_ff @(posedge clk) begin
    if (res) begin
      rd_busy_q  <= 1'b0;
      rd_iss_q   <= 1'b0;
      ra_q       <= '0;
      iss_vld_q  <= 1'b0;
      out_vld_q  <= 1'b0;
      out_data_q <= '0;
      out_addr_q <= '0;
      sk_vld_q   <= 1'b0;
    end else begin
      iss_vld_q <= rd_issue;
      if (rd_issue) begin
        ra_q <= ra_q + 1'b1;
        if (ra_q == LAST_A) rd_iss_q <= 1'b0;
      end
      if (pop && rd_last_w) rd_busy_q <= 1'b0;
      if (swap) begin
        rd_busy_q <= 1'b1;
        rd_iss_q  <= 1'b1;
        ra_q      <= '0;
      end
      if (out_load) begin
        if (sk_vld_q) begin
          out_vld_q  <= 1'b1;
          out_data_q <= sk_data_q;
          out_addr_q <= sk_addr_q;
        end else begin
          out_vld_q <= iss_vld_q;
          if (iss_vld_q) begin
            out_data_q <= rd_in_data;
            out_addr_q <= iss_addr_q;
          end
        end
        sk_vld_q <= sk_vld_q & iss_vld_q;
      end else begin
        sk_vld_q <= sk_vld_q | iss_vld_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    iss_addr_q <= ra_q;
    if (to_skid) begin
      sk_data_q <= rd_in_data;
      sk_addr_q <= iss_addr_q;
    end
  end

  assign rd_valid   = out_vld_q;
  assign rd_data    = out_data_q;
  assign rd_pix     = out_addr_q[AW-1:NB];
  assign rd_bin     = out_addr_q[NB-1:0];
  assign rd_last    = rd_last_w;
  assign ready      = (state_q != S_INIT);
  assign frame_done = frame_done_q;
  assign next_flag  = next_flag_q;
  assign drop_cnt   = drop_q;

endmodule

// File: tb/tb_hist_pingpong_builder.sv
// Scoreboard bench for hist_pingpong_builder with NB=4, CW=4, NPIX=2, ACQ_NUM=3.
module tb_hist_pingpong_builder;

  logic        clk = 1'b0;
  logic        res = 1'b1;
  logic        laser_sync = 1'b0;
  logic        ts_valid = 1'b0;
  logic [0:0]  ts_pix = '0;
  logic [3:0]  ts_bin = '0;
  logic        rdy = 1'b1;
  logic        rd_valid;
  logic [3:0]  rd_data;
  logic [0:0]  rd_pix;
  logic [3:0]  rd_bin;
  logic        rd_last;
  logic        ready;
  logic        frame_done;
  logic        next_flag;
  logic [15:0] drop_cnt;

  hist_pingpong_builder #(.NB(4), .CW(4), .NPIX(2), .ACQ_NUM(3)) dut (
    .clk(clk), .res(res), .laser_sync(laser_sync), .ts_valid(ts_valid),
    .ts_pix(ts_pix), .ts_bin(ts_bin), .rd_ready(rdy), .rd_valid(rd_valid),
    .rd_data(rd_data), .rd_pix(rd_pix), .rd_bin(rd_bin), .rd_last(rd_last),
    .ready(ready), .frame_done(frame_done), .next_flag(next_flag), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [3:0] d; logic [4:0] a; } beat_t;
  beat_t exp_q[$];

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int beat_cnt = 0;
  int last_hs_cyc = -10;
  int mdl[32];
  int exp_drop = 0;
  int lcnt = 0;
  bit acc_ok = 1'b0;
  bit nf_exp = 1'b0;
  bit hold_pend = 1'b0;
  logic [8:0] held = '0;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    beat_t e;
    if (hold_pend && !res) begin
      check("hold_valid", int'(rd_valid), 1);
      check("hold_beat", int'({rd_pix, rd_bin, rd_data}), int'(held));
    end
    hold_pend = rd_valid && !rdy;
    held = {rd_pix, rd_bin, rd_data};
    if (rd_valid && rdy) begin
      if (exp_q.size() == 0) begin
        check("extra_beat", int'({rd_pix, rd_bin}), -1);
      end else begin
        e = exp_q.pop_front();
        check("beat_data", int'(rd_data), int'(e.d));
        check("beat_addr", int'({rd_pix, rd_bin}), int'(e.a));
        check("beat_last", int'(rd_last), int'(e.a == 5'd31));
      end
      beat_cnt++;
      if (rd_last) last_hs_cyc = cyc;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    foreach (mdl[i]) mdl[i] = 0;
    lcnt = 0;
  endtask

  task automatic drive_cycle(input bit v, input int pix, input int bin, input bit ls);
    beat_t b;
    int a;
    a = pix * 16 + bin;
    ts_valid = v;
    ts_pix = 1'(pix);
    ts_bin = 4'(bin);
    laser_sync = ls;
    if (v) begin
      if (acc_ok) mdl[a] = (mdl[a] < 15) ? mdl[a] + 1 : 15;
      else exp_drop++;
    end
    if (ls && acc_ok) begin
      lcnt++;
      if (lcnt == 3) begin
        for (int i = 0; i < 32; i++) begin
          b.d = 4'(mdl[i]);
          b.a = 5'(i);
          exp_q.push_back(b);
        end
        clear_model();
        acc_ok = 1'b0;
      end
    end
    step();
    ts_valid = 1'b0;
    laser_sync = 1'b0;
  endtask

  task automatic hits(input int n, input int pix, input int bin);
    repeat (n) drive_cycle(1'b1, pix, bin, 1'b0);
  endtask

  task automatic end_frame();
    repeat (3) drive_cycle(1'b0, 0, 0, 1'b1);
  endtask

  task automatic wait_swap(input bit hit_en, input int rel_k, input int exp_lat, input bit chk_wait);
    int k;
    k = 1;
    while (frame_done !== 1'b1 && k < 200) begin
      if (hit_en) begin
        ts_valid = 1'b1;
        ts_pix = '0;
        ts_bin = '0;
        exp_drop++;
      end
      if (k == rel_k) rdy = 1'b1;
      step();
      ts_valid = 1'b0;
      k++;
    end
    check("swap_seen", int'(frame_done), 1);
    if (exp_lat > 0) check("swap_latency", k, exp_lat);
    if (chk_wait) begin
      check("waited_for_reader", int'(k > rel_k), 1);
      check("swap_after_last", cyc, last_hs_cyc + 1);
    end
    nf_exp = !nf_exp;
    check("next_flag", int'(next_flag), int'(nf_exp));
    acc_ok = 1'b1;
    beat_cnt = 0;
  endtask

  task automatic drain(input bit rnd);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || rd_valid) && k < 400) begin
      if (rnd) rdy = 1'($urandom_range(0, 1));
      step();
      k++;
    end
    rdy = 1'b1;
    check("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    clear_model();
    // reset and initialisation
    repeat (3) step();
    check("rst_rd_valid", int'(rd_valid), 0);
    check("rst_rd_last", int'(rd_last), 0);
    check("rst_ready", int'(ready), 0);
    check("rst_frame_done", int'(frame_done), 0);
    check("rst_next_flag", int'(next_flag), 0);
    check("rst_drop_cnt", int'(drop_cnt), 0);
    check("rst_rd_beat", int'({rd_pix, rd_bin, rd_data}), 0);
    res = 1'b0;
    for (int i = 0; i < 32; i++) begin
      check("init_ready_low", int'(ready), 0);
      ts_valid = (i >= 1 && i <= 3);
      if (ts_valid) exp_drop++;
      step();
    end
    ts_valid = 1'b0;
    check("init_ready_high", int'(ready), 1);
    check("init_drops", int'(drop_cnt), exp_drop);
    acc_ok = 1'b1;

    // saturating bin, swap latency and readout start
    hits(20, 0, 5);
    end_frame();
    wait_swap(1'b0, 0, 3, 1'b0);
    drive_cycle(1'b0, 0, 0, 1'b0);
    check("frame_done_pulse", int'(frame_done), 0);
    drive_cycle(1'b0, 0, 0, 1'b0);
    check("first_rd_valid", int'(rd_valid), 1);
    drain(1'b0);

    // forwarding patterns, hit on the final laser_sync, random backpressure
    hits(2, 1, 2);
    hits(1, 1, 3);
    hits(1, 1, 2);
    hits(2, 1, 3);
    hits(1, 0, 9);
    hits(1, 1, 9);
    hits(1, 0, 9);
    drive_cycle(1'b0, 0, 0, 1'b1);
    drive_cycle(1'b1, 1, 15, 1'b1);
    drive_cycle(1'b1, 0, 0, 1'b1);
    wait_swap(1'b0, 0, 3, 1'b0);
    drain(1'b1);

    // reader stalled while the next frame ends
    hits(4, 0, 7);
    end_frame();
    wait_swap(1'b0, 0, 3, 1'b0);
    rdy = 1'b0;
    end_frame();
    wait_swap(1'b1, 6, 0, 1'b1);
    drain(1'b0);
    end_frame();
    wait_swap(1'b0, 0, 3, 1'b0);
    drain(1'b0);
    check("drop_total", int'(drop_cnt), exp_drop);

    // reset in the middle of a readout
    hits(2, 1, 1);
    hits(3, 0, 12);
    end_frame();
    wait_swap(1'b0, 0, 3, 1'b0);
    for (int k = 0; k < 100 && beat_cnt < 10; k++) step();
    check("reached_beat10", int'(beat_cnt >= 10), 1);
    res = 1'b1;
    step();
    res = 1'b0;
    check("midrst_rd_valid", int'(rd_valid), 0);
    check("midrst_ready", int'(ready), 0);
    check("midrst_next_flag", int'(next_flag), 0);
    check("midrst_drop_cnt", int'(drop_cnt), 0);
    exp_q.delete();
    clear_model();
    acc_ok = 1'b0;
    exp_drop = 0;
    nf_exp = 1'b0;
    for (int i = 0; i < 32; i++) begin
      if (i == 31) check("reinit_ready_low", int'(ready), 0);
      step();
    end
    check("reinit_ready_high", int'(ready), 1);
    acc_ok = 1'b1;
    hits(1, 0, 3);
    end_frame();
    wait_swap(1'b0, 0, 3, 1'b0);
    drain(1'b0);
    end_frame();
    wait_swap(1'b0, 0, 3, 1'b0);
    drain(1'b0);
    check("final_drops", int'(drop_cnt), exp_drop);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
